// File: rtl/mips_pkg.sv
// Shared MIPS encoder definitions: instruction kind codes, opcodes and FSM states.
package mips_pkg;

  localparam logic [3:0] KIND_LW    = 4'd0;
  localparam logic [3:0] KIND_SW    = 4'd1;
  localparam logic [3:0] KIND_ADDI  = 4'd2;
  localparam logic [3:0] KIND_ANDI  = 4'd3;
  localparam logic [3:0] KIND_ORI   = 4'd4;
  localparam logic [3:0] KIND_SLTI  = 4'd5;
  localparam logic [3:0] KIND_RTYPE = 4'd6;
  localparam logic [3:0] KIND_BEQ   = 4'd7;
  localparam logic [3:0] KIND_BNE   = 4'd8;
  localparam logic [3:0] KIND_J     = 4'd9;
  localparam logic [3:0] KIND_JAL   = 4'd10;
  localparam logic [3:0] KIND_JR    = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of instruction fields into a 32-bit MIPS word.
module instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    unique case (kind)
      KIND_LW:    word = {OP_LW,   rs, rt, imm};
      KIND_SW:    word = {OP_SW,   rs, rt, imm};
      KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
      KIND_ANDI:  word = {OP_ANDI, rs, rt, imm};
      KIND_ORI:   word = {OP_ORI,  rs, rt, imm};
      KIND_SLTI:  word = {OP_SLTI, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm};
      KIND_BNE:   word = {OP_BNE,  rs, rt, imm};
      KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
      KIND_J:     word = {OP_J,   target};
      KIND_JAL:   word = {OP_JAL, target};
      // JR carries only rs; everything between rs and funct is zero
      KIND_JR:    word = {OP_RTYPE, rs, 15'd0, FUNCT_JR};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder writing packed words to sequential instruction-memory addresses.
// Optional macro INSTR_ENCODER_CHECK_EN: reject illegal kinds with an err pulse instead of writing a NOP.
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [31:0]     word;
  logic            illegal;
  logic            accept;
  logic            reject;
  state_t          state;
  logic [31:0]     word_p0;
  logic [ADDR_W:0] cnt_q;

  instr_pack u_pack (
    .kind    (kind),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .funct   (funct),
    .imm     (imm),
    .target  (target),
    .word    (word),
    .illegal (illegal)
  );

  assign accept = in_valid && (state == IDLE) && !clear;

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q;

  assign reject = illegal;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && illegal;
  end

  assign err = err_q;
`else
  logic unused_illegal;

  assign unused_illegal = illegal;
  assign reject         = 1'b0;
  assign err            = 1'b0;
`endif

  // Accept stage: word captured into word_p0, written out on the following WRITE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_p0 <= 32'h0000_0000;
      cnt_q   <= '0;
    end else if (clear) begin
      state <= IDLE;
      cnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && !reject) begin
            word_p0 <= word;
            state   <= WRITE;
          end
        end
        WRITE: begin
          cnt_q <= cnt_q + 1'b1;
          state <= (cnt_q + 1'b1 == DEPTH_C) ? FULL : IDLE;
        end
        FULL:    state <= FULL;
        default: state <= IDLE;
      endcase
    end
  end

  // Pointer equals count since it never wraps; clear/rst abort a pending write this cycle
  assign in_ready = (state == IDLE);
  assign wr_en    = (state == WRITE) && !clear && !rst;
  assign wr_addr  = cnt_q[ADDR_W-1:0];
  assign wr_data  = word_p0;
  assign count    = cnt_q;
  assign full     = (state == FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder (DEPTH=4) against a field-level encoding model.
module tb_instr_encoder;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        kind = '0;
  logic [4:0]        rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]        funct = '0;
  logic [15:0]       imm = '0;
  logic [25:0]       target = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .kind     (kind),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .target   (target),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .full     (full),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference encoding computed from opcode numbers and field bit positions
  function automatic logic [31:0] ref_word(input int k, input int a_rs, input int a_rt,
                                           input int a_rd, input int a_sh, input int a_fn,
                                           input int a_imm, input int a_tgt);
    int op_tab[12] = '{35, 43, 8, 12, 13, 10, 0, 4, 5, 2, 3, 0};
    longint w;
    if (k < 6 || k == 7 || k == 8)
      w = op_tab[k] * (64'd1 << 26) + a_rs * (64'd1 << 21) + a_rt * (64'd1 << 16) + a_imm;
    else if (k == 6)
      w = a_rs * (64'd1 << 21) + a_rt * (64'd1 << 16) + a_rd * (64'd1 << 11) + a_sh * 64 + a_fn;
    else if (k == 9 || k == 10)
      w = op_tab[k] * (64'd1 << 26) + a_tgt;
    else if (k == 11)
      w = a_rs * (64'd1 << 21) + 8;
    else
      w = 0;
    return w[31:0];
  endfunction

  task automatic set_fields(input logic [3:0] k, input logic [4:0] a_rs, input logic [4:0] a_rt,
                            input logic [4:0] a_rd, input logic [4:0] a_sh, input logic [5:0] a_fn,
                            input logic [15:0] a_imm, input logic [25:0] a_tgt);
    kind = k; rs = a_rs; rt = a_rt; rd = a_rd; shamt = a_sh;
    funct = a_fn; imm = a_imm; target = a_tgt;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_cnt = 0;
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_full", 32'(full), 32'd0);
  endtask

  // Present one instruction in IDLE and check the resulting write (or rejection)
  task automatic write_one(input string tag, input logic [31:0] expw);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef INSTR_ENCODER_CHECK_EN
    if (kind >= 4'd12) begin
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_nowr"}, 32'(wr_en), 32'd0);
      chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      tick();
      chk({tag, "_err_clr"}, 32'(err), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
      return;
    end
`endif
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(wr_addr), 32'(exp_cnt));
    chk({tag, "_data"}, wr_data, expw);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    chk({tag, "_err0"}, 32'(err), 32'd0);
    tick();
    exp_cnt++;
    chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    chk({tag, "_full"}, 32'(full), 32'(exp_cnt == DEPTH));
    chk({tag, "_wr_off"}, 32'(wr_en), 32'd0);
  endtask

  initial begin
    int nwr;
    int k;
    logic [31:0] w;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    set_fields(4'd0, 5'd2, 5'd3, 5'd7, 5'd9, 6'h3f, 16'h0004, 26'h3ffffff);
    write_one("lw", 32'h8C43_0004);
    do_clear();

    set_fields(4'd6, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hffff, 26'h155_5555);
    write_one("add", 32'h0022_1820);
    set_fields(4'd11, 5'd31, 5'd5, 5'd6, 5'd7, 6'h11, 16'h1234, 26'h2aa_aaaa);
    write_one("jr", 32'h03E0_0008);
    do_clear();

    // Back-to-back J: in_ready toggles every cycle while in_valid stays high
    set_fields(4'd9, 5'd4, 5'd5, 5'd6, 5'd7, 6'h01, 16'h8888, 26'h000_0100);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("j_ready", 32'(in_ready), 32'(i % 2 == 0));
      if (i % 2 == 1) begin
        chk("j_wr_en", 32'(wr_en), 32'd1);
        chk("j_data", wr_data, 32'h0800_0100);
      end
      tick();
    end
    in_valid = 1'b0;
    chk("j_count", 32'(count), 32'd2);
    do_clear();

    // Five words offered against DEPTH=4: only four writes, then full
    set_fields(4'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0001, 26'h0);
    in_valid = 1'b1;
    nwr = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_en) begin
        chk("fill_addr", 32'(wr_addr), 32'(nwr));
        nwr++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("fill_writes", 32'(nwr), 32'd4);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(in_ready), 32'd0);
    chk("fill_count", 32'(count), 32'd4);
    do_clear();
    write_one("after_clear", 32'h2021_0001);

    // clear during WRITE aborts the pending write
    set_fields(4'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h00ff, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clrw_wr_en", 32'(wr_en), 32'd0);
    tick();
    clear = 1'b0;
    exp_cnt = 0;
    chk("clrw_count", 32'(count), 32'd0);
    chk("clrw_ready", 32'(in_ready), 32'd1);
    chk("clrw_no_late", 32'(wr_en), 32'd0);

    // clear with simultaneous in_valid is not an accept
    in_valid = 1'b1;
    clear = 1'b1;
    tick();
    in_valid = 1'b0;
    clear = 1'b0;
    chk("clrv_wr_en", 32'(wr_en), 32'd0);
    chk("clrv_ready", 32'(in_ready), 32'd1);

    // rst during WRITE suppresses the write
    write_one("pre_rst", 32'h3464_00ff);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_wr_en", 32'(wr_en), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_data", wr_data, 32'd0);
    chk("rstw_no_late", 32'(wr_en), 32'd0);

    set_fields(4'd14, 5'd9, 5'd9, 5'd9, 5'd9, 6'h09, 16'h9999, 26'h999_9999);
    write_one("illegal14", 32'h0000_0000);

    for (int it = 0; it < 200; it++) begin
      if (exp_cnt == DEPTH) begin
        chk("rnd_full", 32'(full), 32'd1);
        chk("rnd_full_ready", 32'(in_ready), 32'd0);
        do_clear();
      end else begin
        k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 15)) : int'($urandom_range(0, 11));
        set_fields(4'(k), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   6'($urandom), 16'($urandom), 26'($urandom));
        w = ref_word(k, int'(rs), int'(rt), int'(rd), int'(shamt), int'(funct),
                     int'(imm), int'(target));
        write_one("rnd", w);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning the number of words writable before full; DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous restart of the write pointer.
REQ-006 SHALL have port in_valid  input  1  the instruction fields are valid.
REQ-007 SHALL have port in_ready  output  1  the encoder accepts fields this cycle.
REQ-008 SHALL have port kind  input  4  instruction class: 0 LW, 1 SW, 2 ADDI, 3 ANDI, 4 ORI, 5 SLTI, 6 RTYPE, 7 BEQ, 8 BNE, 9 J, 10 JAL, 11 JR; 12-15 illegal.
REQ-009 SHALL have ports rs, rt, rd, shamt  input  5 each  register and shift fields.
REQ-010 SHALL have ports funct (input, 6), imm (input, 16) and target (input, 26), carrying the R-type function field, the I-type immediate and the J-type target.
REQ-011 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-012 SHALL have port wr_addr  output  ADDR_W  word address of the write.
REQ-013 SHALL have port wr_data  output  32  encoded MIPS word.
REQ-014 SHALL have port count  output  ADDR_W+1  number of words written since reset or clear.
REQ-015 SHALL have port full  output  1  DEPTH words have been written.
REQ-016 SHALL have port err  output  1  one-cycle pulse when an illegal kind is rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, WRITE and FULL.
REQ-018 In IDLE, in_ready SHALL be 1; all other states SHALL hold in_ready at 0.
REQ-019 Fields SHALL be accepted only on a cycle where in_valid and in_ready are both 1; the encoded word SHALL be registered in that cycle and the FSM SHALL go to WRITE.
REQ-020 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr equal to the current pointer and wr_data equal to the word registered at accept; latency from accept to wr_en SHALL be 1 cycle, and throughput SHALL be 1 word per 2 cycles.
REQ-021 After WRITE, the pointer and count SHALL increment by 1; the FSM SHALL go to FULL if the new count equals DEPTH, otherwise to IDLE.
REQ-022 Encodings SHALL be built with opcode[31:26], rs[25:21], rt[20:16] and imm[15:0]: LW 100011, SW 101011, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, BEQ 000100, BNE 000101.
REQ-023 RTYPE SHALL be encoded as 000000 with rs, rt, rd[15:11], shamt[10:6] and funct[5:0].
REQ-024 J SHALL be encoded as 000010 with target[25:0]; JAL SHALL be encoded as 000011 with target[25:0].
REQ-025 JR SHALL be encoded as 000000 with rs, bits[20:6]=0 and funct 001000; the rt, rd, shamt and funct inputs SHALL be ignored.
REQ-026 Input fields unused by a kind SHALL NOT affect wr_data.
REQ-027 FULL SHALL hold full=1 and wr_en=0, and SHALL be left only by clear or rst.
REQ-028 clear=1 in any state SHALL go to IDLE with pointer=0 and count=0, and SHALL force wr_en=0 in that cycle, aborting any pending write; a simultaneous in_valid SHALL NOT be accepted.
REQ-029 The pointer SHALL never wrap; writes beyond DEPTH SHALL be impossible.

Reset
REQ-030 rst SHALL dominate clear and all inputs.
REQ-031 On rst, the state SHALL be IDLE, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0 and err=0.
REQ-032 A reset asserted during WRITE SHALL suppress that write.

Configuration
REQ-033 Macro INSTR_ENCODER_CHECK_EN SHALL control illegal-kind handling.
REQ-034 With INSTR_ENCODER_CHECK_EN defined, an accepted illegal kind SHALL pulse err for 1 cycle, the FSM SHALL stay in IDLE, no write SHALL occur and the pointer SHALL be unchanged.
REQ-035 Without INSTR_ENCODER_CHECK_EN, an illegal kind SHALL encode as 32'h00000000 (NOP) and be written normally, and err SHALL be tied to 0.

Structure
REQ-036 Package mips_pkg SHALL hold the kind codes, the 6-bit opcode constants, the JR funct constant and the FSM state typedef.
REQ-037 Combinational field packing SHALL reside in sub-module instr_pack, taking (kind, fields) and producing (word, illegal); instr_encoder SHALL own the FSM, the pointer and the registers.

Verification
REQ-038 Bench SHALL apply rst, then LW rs=2 rt=3 imm=16'h0004 -> one cycle later wr_en=1, wr_addr=0, wr_data=32'h8C430004, count=1.
REQ-039 Bench SHALL apply RTYPE add rs=1 rt=2 rd=3 shamt=0 funct=6'h20, then JR rs=31 -> wr_data=32'h00221820, then 32'h03E00008, at addresses 0 and 1.
REQ-040 Bench SHALL apply J target=26'h0000100 with in_valid held high back-to-back -> in_ready alternates 1/0 and wr_data=32'h08000100.
REQ-041 Bench SHALL use DEPTH=4 and 5 valid words -> exactly 4 writes at addresses 0-3, then full=1 and in_ready=0; clear -> full=0, next write goes to address 0.
REQ-042 Bench SHALL assert clear, and separately rst, in the WRITE cycle -> no wr_en and count=0.
REQ-043 Bench SHALL apply kind=14 -> with INSTR_ENCODER_CHECK_EN, err pulses and no write occurs; without it, 32'h00000000 is written.
